// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller.
package game_pkg;

  localparam int COORD_W = 11;
  localparam logic [COORD_W-1:0] Y_FRAME_SIZE = 11'd479;

  // Top-level game states; the encodings appear directly on gameState.
  typedef enum logic [2:0] {
    WELCOME     = 3'd0,
    PLAY        = 3'd1,
    PAUSE       = 3'd2,
    LEVEL_CLEAR = 3'd3,
    GAME_OVER   = 3'd4,
    WIN         = 3'd5
  } game_state_t;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for a level-sensitive key: remembers the previous
// sample so a held key produces exactly one rise.
module key_edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic key,
  output logic rise
);

  logic key_prev_reg;

  // Previous-cycle sample of the key.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) key_prev_reg <= 1'b0;
    else         key_prev_reg <= key;
  end

  assign rise = key & ~key_prev_reg;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: welcome/play/pause/level-clear/game-over/win
// sequencing, lives and invulnerability, level progression and rope firing.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_LIVES     = 3,
  parameter int NUM_LEVELS    = 4,
  parameter int NUM_ROPES     = 2,
  parameter int INVULN_FRAMES = 60,
  parameter int CLEAR_FRAMES  = 90
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic                           rightArrow,
  input  logic                           leftArrow,
  input  logic                           spaceBar,
  input  logic                           pauseKey,
  input  logic                           col_player_ball,
  input  logic [NUM_ROPES-1:0]           col_rope_ball,
  input  logic                           allBallsPopped,
  input  logic [COORD_W-1:0]             playerX,
  input  logic [NUM_ROPES*COORD_W-1:0]   ropeTopY,
  output logic [2:0]                     gameState,
  output logic [2:0]                     level,
  output logic [2:0]                     lives,
  output logic                           playerMoveRight,
  output logic                           playerMoveLeft,
  output logic                           playerVisible,
  output logic                           ballVisible,
  output logic                           playerBlink,
  output logic                           levelLoad,
  output logic [NUM_ROPES-1:0]           ropeActive,
  output logic [NUM_ROPES*COORD_W-1:0]   ropeX
);

  localparam int INV_W = (INVULN_FRAMES < 1) ? 1 : $clog2(INVULN_FRAMES + 1);
  localparam int CLR_W = (CLEAR_FRAMES < 1) ? 1 : $clog2(CLEAR_FRAMES + 1);

  game_state_t        state_reg;
  logic [2:0]         lives_reg;
  logic [2:0]         level_reg;
  logic [INV_W-1:0]   invuln_cnt_reg;
  logic [CLR_W-1:0]   clear_cnt_reg;
  logic               level_load_reg;
  logic [NUM_ROPES-1:0] rope_active_reg;
  logic [COORD_W-1:0] rope_x_reg [NUM_ROPES];
  logic [COORD_W-1:0] rope_top_y [NUM_ROPES];

  logic space_rise;
  logic pause_rise;
  logic in_play;
  logic in_pause;
  logic hit_ok;
  logic fatal_hit;
  logic goto_clear;
  logic rope_clear;
  logic fire;
  logic rope_free_seen;
  logic [NUM_ROPES-1:0] fire_sel;
  logic [NUM_ROPES-1:0] rope_done;

  key_edge_detect u_space_edge (
    .clk    (clk),
    .resetN (resetN),
    .key    (spaceBar),
    .rise   (space_rise)
  );

  key_edge_detect u_pause_edge (
    .clk    (clk),
    .resetN (resetN),
    .key    (pauseKey),
    .rise   (pause_rise)
  );

  // Unpack per-rope coordinates and derive each rope's retire condition.
  for (genvar gi = 0; gi < NUM_ROPES; gi++) begin : g_rope
    assign rope_top_y[gi] = ropeTopY[gi*COORD_W +: COORD_W];
    assign ropeX[gi*COORD_W +: COORD_W] = rope_x_reg[gi];
    assign rope_done[gi] = rope_active_reg[gi] &
                           ((rope_top_y[gi] == '0) | col_rope_ball[gi]);
  end

  assign in_play  = (state_reg == PLAY);
  assign in_pause = (state_reg == PAUSE);

  // A hit counts only when not invulnerable; the last life ends the game,
  // which overrides pause and level completion arriving in the same cycle.
  assign hit_ok     = in_play & col_player_ball & (invuln_cnt_reg == '0) &
                      (lives_reg != 3'd0);
  assign fatal_hit  = hit_ok & (lives_reg == 3'd1);
  assign goto_clear = in_play & ~fatal_hit & ~pause_rise & allBallsPopped;
  assign rope_clear = fatal_hit | goto_clear;
  assign fire       = in_play & space_rise & ~rope_clear;

  // Pick the lowest-index rope idle at this cycle; a rope retiring now is
  // still active and therefore cannot be chosen.
  always_comb begin
    fire_sel       = '0;
    rope_free_seen = 1'b0;
    for (int i = 0; i < NUM_ROPES; i++) begin
      if (!rope_active_reg[i] && !rope_free_seen) begin
        fire_sel[i]    = fire;
        rope_free_seen = 1'b1;
      end
    end
  end

  // Rope activity and fire-time X latch.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rope_active_reg <= '0;
      for (int i = 0; i < NUM_ROPES; i++) rope_x_reg[i] <= '0;
    end else if (rope_clear || !(in_play || in_pause)) begin
      rope_active_reg <= '0;
    end else if (in_play) begin
      for (int i = 0; i < NUM_ROPES; i++) begin
        if (fire_sel[i]) begin
          rope_active_reg[i] <= 1'b1;
          rope_x_reg[i]      <= playerX;
        end else if (rope_done[i]) begin
          rope_active_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Main game FSM with lives, level, invulnerability and clear-frame counters.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg      <= WELCOME;
      lives_reg      <= 3'(NUM_LIVES);
      level_reg      <= 3'd0;
      invuln_cnt_reg <= '0;
      clear_cnt_reg  <= '0;
      level_load_reg <= 1'b0;
    end else begin
      level_load_reg <= 1'b0;
      case (state_reg)
        WELCOME: begin
          if (space_rise) begin
            state_reg      <= PLAY;
            lives_reg      <= 3'(NUM_LIVES);
            level_reg      <= 3'd0;
            invuln_cnt_reg <= '0;
            level_load_reg <= 1'b1;
          end
        end
        PLAY: begin
          if (hit_ok) begin
            lives_reg      <= lives_reg - 3'd1;
            invuln_cnt_reg <= INV_W'(INVULN_FRAMES);
          end else if (startOfFrame && invuln_cnt_reg != '0) begin
            invuln_cnt_reg <= invuln_cnt_reg - 1'b1;
          end
          if (fatal_hit) begin
            state_reg <= GAME_OVER;
          end else if (pause_rise) begin
            state_reg <= PAUSE;
          end else if (goto_clear) begin
            state_reg     <= LEVEL_CLEAR;
            clear_cnt_reg <= '0;
          end
        end
        PAUSE: begin
          if (pause_rise) state_reg <= PLAY;
        end
        LEVEL_CLEAR: begin
          if (startOfFrame) begin
            if (clear_cnt_reg == CLR_W'(CLEAR_FRAMES - 1)) begin
              if (level_reg == 3'(NUM_LEVELS - 1)) begin
                state_reg <= WIN;
              end else begin
                state_reg      <= PLAY;
                level_reg      <= level_reg + 3'd1;
                invuln_cnt_reg <= '0;
                level_load_reg <= 1'b1;
              end
            end else begin
              clear_cnt_reg <= clear_cnt_reg + 1'b1;
            end
          end
        end
        GAME_OVER, WIN: begin
          if (space_rise) state_reg <= WELCOME;
        end
        default: state_reg <= WELCOME;
      endcase
    end
  end

  assign gameState       = state_reg;
  assign level           = level_reg;
  assign lives           = lives_reg;
  assign playerMoveRight = in_play & rightArrow;
  assign playerMoveLeft  = in_play & leftArrow;
  assign playerVisible   = in_play | in_pause | (state_reg == LEVEL_CLEAR);
  assign ballVisible     = in_play | in_pause;
  assign playerBlink     = (invuln_cnt_reg != '0);
  assign levelLoad       = level_load_reg;
  assign ropeActive      = rope_active_reg & {NUM_ROPES{in_play | in_pause}};

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: a per-cycle vector table for the opening
// of a game followed by hand-written multi-cycle sequences.
module tb_game_flow_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame, rightArrow, leftArrow, spaceBar, pauseKey;
  logic        col_player_ball, allBallsPopped;
  logic [1:0]  col_rope_ball;
  logic [10:0] playerX;
  logic [21:0] ropeTopY;
  logic [2:0]  gameState, level, lives;
  logic        playerMoveRight, playerMoveLeft, playerVisible, ballVisible;
  logic        playerBlink, levelLoad;
  logic [1:0]  ropeActive;
  logic [21:0] ropeX;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .NUM_LIVES(3), .NUM_LEVELS(2), .NUM_ROPES(2),
    .INVULN_FRAMES(4), .CLEAR_FRAMES(2)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .rightArrow(rightArrow), .leftArrow(leftArrow), .spaceBar(spaceBar),
    .pauseKey(pauseKey), .col_player_ball(col_player_ball),
    .col_rope_ball(col_rope_ball), .allBallsPopped(allBallsPopped),
    .playerX(playerX), .ropeTopY(ropeTopY), .gameState(gameState),
    .level(level), .lives(lives), .playerMoveRight(playerMoveRight),
    .playerMoveLeft(playerMoveLeft), .playerVisible(playerVisible),
    .ballVisible(ballVisible), .playerBlink(playerBlink),
    .levelLoad(levelLoad), .ropeActive(ropeActive), .ropeX(ropeX)
  );

  typedef struct packed {
    logic        space, pause, right, left, sof, colpb, topy0z;
    logic [10:0] px;
    logic [2:0]  e_state, e_lives;
    logic [1:0]  e_ra;
    logic        e_ll, e_blink, e_mr, e_ml, e_vis;
    logic [10:0] e_rx0, e_rx1;
  } vec_t;

  vec_t vecs [0:18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    startOfFrame = 0; rightArrow = 0; leftArrow = 0; spaceBar = 0; pauseKey = 0;
    col_player_ball = 0; allBallsPopped = 0; col_rope_ball = 2'b00;
    ropeTopY = {11'd300, 11'd300};
  endtask

  task automatic sof_frames(input int n);
    startOfFrame = 1;
    repeat (n) step();
    startOfFrame = 0;
  endtask

  initial begin
    //          sp pa ri le sof hit ty0  px     st li ra    ll bl mr ml vis rx0  rx1
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0,   11'd0,   3'd0, 3'd3, 2'b00, 0, 0, 0, 0, 0, 11'd0, 11'd0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 0,   11'd0,   3'd1, 3'd3, 2'b00, 1, 0, 0, 0, 1, 11'd0, 11'd0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0,   11'd100, 3'd1, 3'd3, 2'b00, 0, 0, 0, 0, 1, 11'd0, 11'd0};
    vecs[3]  = '{1, 0, 0, 0, 0, 0, 0,   11'd100, 3'd1, 3'd3, 2'b01, 0, 0, 0, 0, 1, 11'd100, 11'd0};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0,   11'd200, 3'd1, 3'd3, 2'b01, 0, 0, 0, 0, 1, 11'd100, 11'd0};
    vecs[5]  = '{1, 0, 0, 0, 0, 0, 0,   11'd200, 3'd1, 3'd3, 2'b11, 0, 0, 0, 0, 1, 11'd100, 11'd200};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0,   11'd200, 3'd1, 3'd3, 2'b11, 0, 0, 0, 0, 1, 11'd100, 11'd200};
    vecs[7]  = '{1, 0, 0, 0, 0, 0, 0,   11'd300, 3'd1, 3'd3, 2'b11, 0, 0, 0, 0, 1, 11'd100, 11'd200};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 1,   11'd300, 3'd1, 3'd3, 2'b10, 0, 0, 0, 0, 1, 11'd100, 11'd200};
    vecs[9]  = '{0, 0, 1, 0, 0, 0, 0,   11'd300, 3'd1, 3'd3, 2'b10, 0, 0, 1, 0, 1, 11'd100, 11'd200};
    vecs[10] = '{0, 0, 1, 1, 0, 0, 0,   11'd300, 3'd1, 3'd3, 2'b10, 0, 0, 1, 1, 1, 11'd100, 11'd200};
    vecs[11] = '{0, 0, 0, 0, 1, 1, 0,   11'd300, 3'd1, 3'd2, 2'b10, 0, 1, 0, 0, 1, 11'd100, 11'd200};
    vecs[12] = '{0, 0, 0, 0, 1, 0, 0,   11'd300, 3'd1, 3'd2, 2'b10, 0, 1, 0, 0, 1, 11'd100, 11'd200};
    vecs[13] = '{0, 0, 0, 0, 1, 1, 0,   11'd300, 3'd1, 3'd2, 2'b10, 0, 1, 0, 0, 1, 11'd100, 11'd200};
    vecs[14] = '{0, 0, 0, 0, 1, 0, 0,   11'd300, 3'd1, 3'd2, 2'b10, 0, 1, 0, 0, 1, 11'd100, 11'd200};
    vecs[15] = '{0, 0, 0, 0, 1, 0, 0,   11'd300, 3'd1, 3'd2, 2'b10, 0, 0, 0, 0, 1, 11'd100, 11'd200};
    vecs[16] = '{0, 0, 0, 0, 0, 1, 0,   11'd300, 3'd1, 3'd1, 2'b10, 0, 1, 0, 0, 1, 11'd100, 11'd200};
    vecs[17] = '{0, 0, 0, 0, 1, 0, 0,   11'd300, 3'd1, 3'd1, 2'b10, 0, 1, 0, 0, 1, 11'd100, 11'd200};
    vecs[18] = '{0, 1, 0, 0, 0, 0, 0,   11'd300, 3'd2, 3'd1, 2'b10, 0, 1, 0, 0, 1, 11'd100, 11'd200};

    resetN = 1'b0;
    playerX = '0;
    clear_inputs();
    step();
    step();
    chk("reset_state", gameState, 0);
    chk("reset_lives", lives, 3);
    chk("reset_level", level, 0);
    chk("reset_rope", ropeActive, 0);
    chk("reset_ropex", ropeX, 0);
    chk("reset_ll", levelLoad, 0);
    resetN = 1'b1;

    // Opening of a game, one record per clock cycle.
    for (int k = 0; k <= 18; k++) begin
      spaceBar        = vecs[k].space;
      pauseKey        = vecs[k].pause;
      rightArrow      = vecs[k].right;
      leftArrow       = vecs[k].left;
      startOfFrame    = vecs[k].sof;
      col_player_ball = vecs[k].colpb;
      playerX         = vecs[k].px;
      ropeTopY        = {11'd300, vecs[k].topy0z ? 11'd0 : 11'd300};
      step();
      $display("vec %0d state=%0d lives=%0d rope=%b ll=%0d blink=%0d",
               k, gameState, lives, ropeActive, levelLoad, playerBlink);
      chk("v_state", gameState, vecs[k].e_state);
      chk("v_lives", lives, vecs[k].e_lives);
      chk("v_level", level, 0);
      chk("v_rope", ropeActive, vecs[k].e_ra);
      chk("v_ll", levelLoad, vecs[k].e_ll);
      chk("v_blink", playerBlink, vecs[k].e_blink);
      chk("v_mr", playerMoveRight, vecs[k].e_mr);
      chk("v_ml", playerMoveLeft, vecs[k].e_ml);
      chk("v_pvis", playerVisible, vecs[k].e_vis);
      chk("v_bvis", ballVisible, vecs[k].e_vis);
      chk("v_rx0", ropeX[10:0], vecs[k].e_rx0);
      chk("v_rx1", ropeX[21:11], vecs[k].e_rx1);
    end
    clear_inputs();

    // Paused with invulnerability counter at 3: ten frames change nothing.
    for (int f = 0; f < 10; f++) begin
      startOfFrame = 1; rightArrow = 1; leftArrow = 1;
      step();
      chk("pause_state", gameState, 2);
      chk("pause_mr", playerMoveRight, 0);
      chk("pause_ml", playerMoveLeft, 0);
      chk("pause_blink", playerBlink, 1);
      chk("pause_rope", ropeActive, 2'b10);
    end
    $display("pause frames done state=%0d", gameState);
    clear_inputs();
    pauseKey = 1;
    step();
    chk("unpause_state", gameState, 1);
    pauseKey = 0;
    sof_frames(2);
    chk("resume_blink2", playerBlink, 1);
    sof_frames(1);
    chk("resume_blink3", playerBlink, 0);
    $display("resume state=%0d blink=%0d", gameState, playerBlink);

    // Last life lost.
    col_player_ball = 1;
    step();
    col_player_ball = 0;
    $display("fatal hit state=%0d lives=%0d", gameState, lives);
    chk("over_state", gameState, 4);
    chk("over_lives", lives, 0);
    chk("over_rope", ropeActive, 0);
    chk("over_pvis", playerVisible, 0);
    spaceBar = 1; step(); spaceBar = 0;
    chk("over_to_welcome", gameState, 0);
    step();

    // New game, level clear, level 1, then win.
    spaceBar = 1; step(); spaceBar = 0;
    chk("g2_state", gameState, 1);
    chk("g2_lives", lives, 3);
    chk("g2_ll", levelLoad, 1);
    step();
    chk("g2_ll_end", levelLoad, 0);
    playerX = 11'd50; spaceBar = 1; step(); spaceBar = 0;
    chk("g2_rope", ropeActive, 2'b01);
    chk("g2_rx0", ropeX[10:0], 50);
    allBallsPopped = 1; step(); allBallsPopped = 0;
    $display("level clear state=%0d", gameState);
    chk("clr_state", gameState, 3);
    chk("clr_rope", ropeActive, 0);
    chk("clr_pvis", playerVisible, 1);
    chk("clr_bvis", ballVisible, 0);
    sof_frames(1);
    chk("clr_hold", gameState, 3);
    sof_frames(1);
    chk("l1_state", gameState, 1);
    chk("l1_level", level, 1);
    chk("l1_ll", levelLoad, 1);
    step();
    chk("l1_ll_end", levelLoad, 0);
    allBallsPopped = 1; step(); allBallsPopped = 0;
    chk("clr2_state", gameState, 3);
    sof_frames(2);
    $display("win state=%0d level=%0d", gameState, level);
    chk("win_state", gameState, 5);
    chk("win_level", level, 1);
    chk("win_pvis", playerVisible, 0);
    spaceBar = 1; step(); spaceBar = 0;
    chk("win_to_welcome", gameState, 0);
    step();

    // Fatal hit coinciding with allBallsPopped and pause.
    spaceBar = 1; step(); spaceBar = 0;
    col_player_ball = 1; step(); col_player_ball = 0;
    sof_frames(4);
    col_player_ball = 1; step(); col_player_ball = 0;
    chk("g3_lives", lives, 1);
    sof_frames(4);
    col_player_ball = 1; allBallsPopped = 1; pauseKey = 1;
    step();
    clear_inputs();
    $display("fatal+popped state=%0d lives=%0d", gameState, lives);
    chk("prio_state", gameState, 4);
    chk("prio_lives", lives, 0);
    step();

    // Reset during LEVEL_CLEAR.
    spaceBar = 1; step(); spaceBar = 0; step();
    spaceBar = 1; step(); spaceBar = 0;
    chk("g4_state", gameState, 1);
    playerX = 11'd77; spaceBar = 1; step(); spaceBar = 0;
    allBallsPopped = 1; step(); allBallsPopped = 0;
    chk("g4_clear", gameState, 3);
    sof_frames(1);
    #2 resetN = 1'b0;
    #1;
    $display("async reset state=%0d rope=%b", gameState, ropeActive);
    chk("rst_state", gameState, 0);
    chk("rst_rope", ropeActive, 0);
    chk("rst_ropex", ropeX, 0);
    chk("rst_lives", lives, 3);
    chk("rst_level", level, 0);
    step();
    resetN = 1'b1;
    step();
    chk("post_rst_state", gameState, 0);
    chk("post_rst_ll", levelLoad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Clock and reset SHALL be a single clock `clk` and reset `resetN`, asynchronous and active-low.
REQ-002 Parameters SHALL be:
- NUM_LIVES, default 3: lives loaded at game start (1..7).
- NUM_LEVELS, default 4: levels per game (1..8).
- NUM_ROPES, default 2: independent ropes (1..4).
- INVULN_FRAMES, default 60: frames of post-hit immunity.
- CLEAR_FRAMES, default 90: frames held in level-clear.

REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: system clock.
- resetN, in, 1: async active-low reset.
- startOfFrame, in, 1: one-cycle frame tick.
- rightArrow, in, 1: right key level.
- leftArrow, in, 1: left key level.
- spaceBar, in, 1: fire/start key level.
- pauseKey, in, 1: pause key level.
- col_player_ball, in, 1: player-ball collision.
- col_rope_ball, in, NUM_ROPES: per-rope ball collision.
- allBallsPopped, in, 1: no balls remain.
- playerX, in, 11: player X coordinate.
- ropeTopY, in, NUM_ROPES*11: packed rope tip Y coordinates, rope i at [11i+10:11i].
- gameState, out, 3: state code.
- level, out, 3: current level, 0-based.
- lives, out, 3: remaining lives.
- playerMoveRight, out, 1: move-right request.
- playerMoveLeft, out, 1: move-left request.
- playerVisible, out, 1: draw player.
- ballVisible, out, 1: draw balls.
- playerBlink, out, 1: player is invulnerable.
- levelLoad, out, 1: one-cycle pulse that loads level ball set.
- ropeActive, out, NUM_ROPES: per-rope active flag.
- ropeX, out, NUM_ROPES*11: packed rope X coordinates, latched at fire.

Function
REQ-004 The FSM SHALL use these states and gameState codes: WELCOME=0, PLAY=1, PAUSE=2, LEVEL_CLEAR=3, GAME_OVER=4, WIN=5.
REQ-005 spaceBar and pauseKey SHALL be acted on only at their rising edge (registered previous value; 1-cycle latency); held keys SHALL NOT retrigger.
REQ-006 WELCOME SHALL go to PLAY on a spaceBar rise; that same cycle SHALL load lives=NUM_LIVES, level=0, invulnerability counter=0, and pulse levelLoad.
REQ-007 PLAY SHALL go to PAUSE on a pauseKey rise. PAUSE SHALL return to PLAY on the next pauseKey rise.
REQ-008 In PAUSE:
- move outputs are 0.
- ropes, lives and the invulnerability counter are frozen.
- playerVisible=ballVisible=1.
REQ-009 In PLAY, playerMoveRight and playerMoveLeft SHALL mirror the arrow keys combinationally; both keys held SHALL drive both outputs to 1.
REQ-010 Rope fire SHALL work as follows:
- A spaceBar rise in PLAY activates the lowest-index rope that is inactive at that cycle, and latches its ropeX from playerX.
- If all ropes are active, the fire is ignored.
REQ-011 Rope i SHALL deactivate next cycle when ropeTopY[i]==0 or col_rope_ball[i]; a rope deactivating this cycle SHALL NOT be re-fired in the same cycle.
REQ-012 A hit SHALL be processed as follows:
- A col_player_ball with invulnerability counter==0 decrements lives and loads the counter with INVULN_FRAMES.
- Hits while the counter is nonzero are ignored.
- The counter decrements on each startOfFrame in PLAY and saturates at 0.
- playerBlink = (counter!=0).
REQ-013 A hit that takes lives to 0 SHALL move PLAY to GAME_OVER next cycle. This SHALL take priority over pauseKey and allBallsPopped in the same cycle.
REQ-014 allBallsPopped in PLAY (no fatal hit) SHALL move to LEVEL_CLEAR, clear all ropes, and start a frame counter.
REQ-015 LEVEL_CLEAR SHALL exit after CLEAR_FRAMES startOfFrame ticks:
- If level==NUM_LEVELS-1, go to WIN.
- Otherwise increment level, pulse levelLoad, clear the invulnerability counter, and go to PLAY.
REQ-016 GAME_OVER and WIN SHALL return to WELCOME on a spaceBar rise.
REQ-017 ropeActive SHALL be 0 in every state except PLAY and PAUSE. playerVisible and ballVisible SHALL be 1 only in PLAY, PAUSE and LEVEL_CLEAR (ballVisible=0 in LEVEL_CLEAR).
REQ-018 The lives counter SHALL never underflow below 0, and level SHALL never exceed NUM_LEVELS-1.

Reset
REQ-019 On resetN low, the block SHALL asynchronously clear its state:
- state=WELCOME.
- lives=NUM_LIVES, level=0.
- ropeActive=0, ropeX=0.
- all counters 0.
- edge-detect registers 0.
- levelLoad=0.
REQ-020 Reset asserted mid-game SHALL abort immediately with no pending pulses after release.

Structure
REQ-021 Package game_pkg SHALL hold:
- the state enum with its codes.
- COORD_W=11.
- Y_FRAME_SIZE=479.
REQ-022 Sub-module key_edge_detect SHALL provide registered rising-edge detection. It SHALL be instantiated once for spaceBar and once for pauseKey.

Verification
REQ-023 The bench SHALL use parameters NUM_LIVES=3, NUM_ROPES=2, INVULN_FRAMES=4, CLEAR_FRAMES=2, NUM_LEVELS=2, and SHALL cover:
- Space rise in WELCOME -> gameState 1, lives 3, level 0, one levelLoad pulse.
- playerX=100 then 200, with a space rise at each -> ropeX[0]=100, ropeX[1]=200, ropeActive=2'b11. A third rise -> no change. Set ropeTopY[0]=0 -> ropeActive=2'b10.
- Hit at frame 0, second hit 2 frames later -> lives 2 only. After 4 frames, hit -> lives 1. Next hit after 4 frames -> GAME_OVER (code 4).
- Pause rise mid-invulnerability, 10 frames, pause rise -> counter unchanged, moves 0 while paused.
- allBallsPopped at level 0 -> LEVEL_CLEAR, then after 2 frames -> level 1, levelLoad pulse. allBallsPopped again -> WIN (code 5).
- Fatal hit with allBallsPopped in the same cycle -> GAME_OVER. resetN low during LEVEL_CLEAR -> WELCOME, ropes 0.
